// File: rtl/stack_tos_unit.sv
// Stack with the top element cached in a register and the remainder in a synchronous RAM.
// Optional high-water mark on MAX_COUNT is enabled by defining STACK_TOS_WATERMARK_EN.
module stack_tos_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  OP_VALID,
   input  logic [2:0]            OP_CODE,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic [ADDR_WIDTH:0]   COUNT_IN,
   input  logic                  ERR_CLEAR,
   output logic                  OP_READY,
   output logic [DATA_WIDTH-1:0] TOP_DATA,
   output logic [ADDR_WIDTH:0]   COUNT_OUT,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  ERR_OVERFLOW,
   output logic                  ERR_UNDERFLOW,
   output logic [ADDR_WIDTH:0]   MAX_COUNT
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CAPACITY = (ADDR_WIDTH + 1)'(DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] CNT_ZERO = (ADDR_WIDTH + 1)'(0);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] CNT_TWO  = (ADDR_WIDTH + 1)'(2);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

   localparam logic [2:0] OP_PUSH        = 3'b001;
   localparam logic [2:0] OP_POP         = 3'b010;
   localparam logic [2:0] OP_REPLACE     = 3'b011;
   localparam logic [2:0] OP_DUP         = 3'b100;
   localparam logic [2:0] OP_POP_REPLACE = 3'b101;
   localparam logic [2:0] OP_SET_COUNT   = 3'b110;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [DATA_WIDTH-1:0]   top_r;
   logic [DATA_WIDTH-1:0]   top_nxt_s;
   logic [ADDR_WIDTH:0]     count_r;
   logic [ADDR_WIDTH:0]     count_nxt_s;
   logic [ADDR_WIDTH:0]     fill_count_r;
   logic [ADDR_WIDTH:0]     fill_count_nxt_s;
   logic                    err_ovf_r;
   logic                    err_unf_r;
   logic                    ovf_set_s;
   logic                    unf_set_s;

   logic                    wr_en_s;
   logic [ADDR_WIDTH-1:0]   wr_addr_s;
   logic                    rd_en_s;
   logic [ADDR_WIDTH-1:0]   rd_addr_s;
   logic [DATA_WIDTH-1:0]   rd_data_r;
   logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

   logic                    empty_s;
   logic                    full_s;
   logic                    accept_s;

   assign empty_s  = (count_r == CNT_ZERO);
   assign full_s   = (count_r == CAPACITY);
   assign accept_s = OP_VALID && (state_r == IDLE);

   // Next-state, storage control and error detection for each operation.
   always_comb begin
      state_nxt_s      = state_r;
      top_nxt_s        = top_r;
      count_nxt_s      = count_r;
      fill_count_nxt_s = fill_count_r;
      ovf_set_s        = 1'b0;
      unf_set_s        = 1'b0;
      wr_en_s          = 1'b0;
      wr_addr_s        = ADDR_WIDTH'(count_r - CNT_ONE);
      rd_en_s          = 1'b0;
      rd_addr_s        = ADDR_WIDTH'(count_r - CNT_TWO);

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               case (OP_CODE)
                  OP_PUSH: begin
                     if (full_s) begin
                        ovf_set_s = 1'b1;
                     end else begin
                        wr_en_s     = !empty_s;
                        top_nxt_s   = DATA_IN;
                        count_nxt_s = count_r + CNT_ONE;
                     end
                  end
                  OP_POP: begin
                     if (empty_s) begin
                        unf_set_s = 1'b1;
                     end else if (count_r == CNT_ONE) begin
                        count_nxt_s = CNT_ZERO;
                     end else begin
                        rd_en_s          = 1'b1;
                        fill_count_nxt_s = count_r - CNT_ONE;
                        state_nxt_s      = FILL;
                     end
                  end
                  OP_REPLACE: begin
                     if (empty_s) begin
                        unf_set_s = 1'b1;
                     end else begin
                        top_nxt_s = DATA_IN;
                     end
                  end
                  OP_DUP: begin
                     if (empty_s) begin
                        unf_set_s = 1'b1;
                     end else if (full_s) begin
                        ovf_set_s = 1'b1;
                     end else begin
                        wr_en_s     = 1'b1;
                        count_nxt_s = count_r + CNT_ONE;
                     end
                  end
                  OP_POP_REPLACE: begin
                     if (count_r < CNT_TWO) begin
                        unf_set_s = 1'b1;
                     end else begin
                        top_nxt_s   = DATA_IN;
                        count_nxt_s = count_r - CNT_ONE;
                     end
                  end
                  OP_SET_COUNT: begin
                     if (COUNT_IN > count_r) begin
                        ovf_set_s = 1'b1;
                     end else if (COUNT_IN == CNT_ZERO) begin
                        count_nxt_s = CNT_ZERO;
                     end else if (COUNT_IN == count_r) begin
                        count_nxt_s = count_r;
                     end else begin
                        rd_en_s          = 1'b1;
                        rd_addr_s        = ADDR_WIDTH'(COUNT_IN - CNT_ONE);
                        fill_count_nxt_s = COUNT_IN;
                        state_nxt_s      = FILL;
                     end
                  end
                  default: begin
                     state_nxt_s = IDLE;
                  end
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FILL: begin
            // The RAM word read in the previous cycle becomes the new cached top.
            top_nxt_s   = rd_data_r;
            count_nxt_s = fill_count_r;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Control and cached-top registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         top_r        <= DATA_ZERO;
         count_r      <= CNT_ZERO;
         fill_count_r <= CNT_ZERO;
      end else begin
         state_r      <= state_nxt_s;
         top_r        <= top_nxt_s;
         count_r      <= count_nxt_s;
         fill_count_r <= fill_count_nxt_s;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_ovf_r <= 1'b0;
         err_unf_r <= 1'b0;
      end else begin
         err_ovf_r <= ovf_set_s || (err_ovf_r && !ERR_CLEAR);
         err_unf_r <= unf_set_s || (err_unf_r && !ERR_CLEAR);
      end
   end

   // Backing RAM write port.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_addr_s] <= top_r;
      end
   end

   // Backing RAM read port, one cycle of latency.
   always_ff @(posedge clk) begin
      if (rd_en_s) begin
         rd_data_r <= mem_r[rd_addr_s];
      end
   end

`ifdef STACK_TOS_WATERMARK_EN
   logic [ADDR_WIDTH:0] max_count_r;

   // High-water mark of the element count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_count_r <= CNT_ZERO;
      end else if (count_nxt_s > max_count_r) begin
         max_count_r <= count_nxt_s;
      end
   end

   assign MAX_COUNT = max_count_r;
`else
   assign MAX_COUNT = CNT_ZERO;
`endif

   assign OP_READY      = (state_r == IDLE);
   assign TOP_DATA      = top_r;
   assign COUNT_OUT     = count_r;
   assign EMPTY         = empty_s;
   assign FULL          = full_s;
   assign ERR_OVERFLOW  = err_ovf_r;
   assign ERR_UNDERFLOW = err_unf_r;

endmodule

// File: doc/stack_tos_unit.md
STACK_TOS_UNIT -- requirements
Module: stack_tos_unit

Interface
REQ-001 Parameter DATA_WIDTH, 8, element width in bits.
REQ-002 Parameter ADDR_WIDTH, 12, backing-RAM address width; CAPACITY = 2**ADDR_WIDTH + 1 elements (RAM plus cached top).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 OP_VALID  input  1  operation request.
REQ-006 OP_CODE  input  3  000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 DUP, 101 POP_REPLACE, 110 SET_COUNT, 111 NOP.
REQ-007 DATA_IN  input  DATA_WIDTH  operand for PUSH/REPLACE/POP_REPLACE.
REQ-008 COUNT_IN  input  ADDR_WIDTH+1  target count for SET_COUNT (frame restore).
REQ-009 ERR_CLEAR  input  1  clears sticky error flags.
REQ-010 OP_READY  output  1  high when an operation can be accepted.
REQ-011 TOP_DATA  output  DATA_WIDTH  cached top element, valid when EMPTY low.
REQ-012 COUNT_OUT  output  ADDR_WIDTH+1  current element count.
REQ-013 EMPTY, FULL  output  1 each  COUNT==0; COUNT==CAPACITY.
REQ-014 ERR_OVERFLOW, ERR_UNDERFLOW  output  1 each  sticky error flags.
REQ-015 MAX_COUNT  output  ADDR_WIDTH+1  high-water mark (see Configuration).

Function
REQ-016 Operation accepted only on cycle with OP_VALID & OP_READY; requests while OP_READY low are ignored, not queued.
REQ-017 Storage: element at stack index i (0 = bottom) held in TOP register if i==COUNT-1, else RAM[i]; RAM synchronous write, synchronous read, 1-cycle read latency, not reset.
REQ-018 FSM states IDLE and FILL; OP_READY = (state==IDLE).
REQ-019 PUSH, COUNT<CAPACITY: if COUNT>0 write RAM[COUNT-1]<=TOP; TOP<=DATA_IN; COUNT+1; single cycle, stays IDLE.
REQ-020 DUP, 0<COUNT<CAPACITY: RAM[COUNT-1]<=TOP; TOP unchanged; COUNT+1; single cycle.
REQ-021 REPLACE, COUNT>=1: TOP<=DATA_IN; COUNT unchanged; single cycle.
REQ-022 POP_REPLACE (binary-op result), COUNT>=2: TOP<=DATA_IN; COUNT-1; single cycle, no RAM access.
REQ-023 POP, COUNT==1: COUNT<=0, TOP unchanged, single cycle; COUNT>=2: issue read RAM[COUNT-2], go FILL; next cycle TOP<=read data, COUNT-1, return IDLE (2 cycles total).
REQ-024 SET_COUNT, COUNT_IN<=COUNT: COUNT_IN==0 -> COUNT<=0, single cycle; COUNT_IN==COUNT -> no change, single cycle; else read RAM[COUNT_IN-1], FILL, then TOP<=data, COUNT<=COUNT_IN.
REQ-025 Overflow: PUSH or DUP at FULL, or SET_COUNT with COUNT_IN>COUNT -> operation dropped, ERR_OVERFLOW<=1.
REQ-026 Underflow: POP/REPLACE/DUP at COUNT==0, POP_REPLACE at COUNT<2 -> operation dropped, ERR_UNDERFLOW<=1.
REQ-027 Errored operation consumes one cycle; state, TOP, COUNT, RAM unchanged.
REQ-028 ERR_CLEAR clears both flags next edge; new error in same cycle wins (flag set).
REQ-029 EMPTY, FULL, OP_READY combinational from registered state; no output depends combinationally on OP_VALID/OP_CODE/DATA_IN.
REQ-030 Counts are unsigned, ADDR_WIDTH+1 bits; never wrap (guarded by REQ-025/026).

Reset
REQ-031 reset asserted: state IDLE, COUNT_OUT 0, TOP_DATA 0, EMPTY 1, FULL 0, OP_READY 1, both error flags 0, MAX_COUNT 0; immediate, independent of clk.
REQ-032 reset during FILL abandons the pending read; RAM contents undefined-but-unchanged.

Configuration
REQ-033 Macro STACK_TOS_WATERMARK_EN defined: MAX_COUNT registers max(MAX_COUNT, new COUNT) each update, cleared only by reset.
REQ-034 Macro undefined: no watermark register; MAX_COUNT tied to 0.

Verification
REQ-035 PUSH 0x11, 0x22, 0x33 -> TOP_DATA 0x33, COUNT_OUT 3; POP -> OP_READY low one cycle, then TOP_DATA 0x22, COUNT_OUT 2.
REQ-036 From empty: POP -> ERR_UNDERFLOW 1, COUNT_OUT 0; ERR_CLEAR -> flag 0 next cycle.
REQ-037 ADDR_WIDTH=2: 5 PUSHes -> FULL 1, 6th PUSH -> ERR_OVERFLOW 1, TOP unchanged, COUNT_OUT 5.
REQ-038 Stack 0x01,0x02,0x03: POP_REPLACE 0x05 -> TOP 0x05, COUNT 2; SET_COUNT 1 -> after 2 cycles TOP 0x01, COUNT 1.
REQ-039 reset asserted mid-FILL -> all outputs at reset values without a clock edge; with STACK_TOS_WATERMARK_EN, 4 pushes then 2 pops -> MAX_COUNT 4.
